// File: rtl/axis_framer_pkg.sv
// axis_framer_pkg
//   Types and helpers shared by the AXI-Stream packet framer and its output
//   register stage.
//   - h_state_e   : hold-register occupancy (EMPTY / HOLD)
//   - clog2_min1  : $clog2 with a floor of 1, so widths never collapse to 0
package axis_framer_pkg;

  typedef enum logic {
    H_EMPTY = 1'b0,
    H_HOLD  = 1'b1
  } h_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_framer_out_reg.sv
// axis_framer_out_reg
//   Single-entry AXI-Stream register slice carrying tdata/tid/tdest/tlast.
//   Accepts a new beat whenever it is empty or its current beat drains in
//   the same cycle, so it sustains one beat per cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready = empty or draining)
//   in_t*                upstream beat fields
//   m_axis_t*            downstream AXI-Stream master
module axis_framer_out_reg #(
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TDATA_WIDTH-1:0] in_tdata,
  input  logic [TID_WIDTH-1:0]   in_tid,
  input  logic [TDEST_WIDTH-1:0] in_tdest,
  input  logic                   in_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TID_WIDTH-1:0]   m_axis_tid,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic                   m_axis_tlast
);

  logic                   valid_q, valid_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [TID_WIDTH-1:0]   tid_q,   tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                   tlast_q, tlast_d;

  always_comb begin
    in_ready = !valid_q || m_axis_tready;
    valid_d  = valid_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    tdest_d  = tdest_q;
    tlast_d  = tlast_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      tdata_d = in_tdata;
      tid_d   = in_tid;
      tdest_d = in_tdest;
      tlast_d = in_tlast;
    end else if (m_axis_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tdata_q <= '0;
      tid_q   <= '0;
      tdest_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tdata_q <= tdata_d;
      tid_q   <= tid_d;
      tdest_q <= tdest_d;
      tlast_q <= tlast_d;
    end
  end

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tdest  = tdest_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: rtl/axis_packet_framer.sv
// axis_packet_framer
//   Turns an unframed AXI-Stream beat stream into bounded, single-destination
//   packets for a NoC ring input. Each accepted beat waits in a hold register
//   until its tlast is known: flush, maximum length, a {tid,tdest} change on
//   the following beat, or (optionally) an idle timeout.
//   Optional feature macro: AXIS_PACKET_FRAMER_TIMEOUT_EN enables the idle
//   timeout counter; without it IDLE_TIMEOUT is unused.
// Ports:
//   clk, rst_n    sole clock, asynchronous active-low reset
//   s_axis_*      user beat input (tflush forces tlast on that beat)
//   m_axis_*      framed output toward the NoC axis_in_* port
//
// state   | meaning
// H_EMPTY | hold register has no beat
// H_HOLD  | hold register has a beat whose tlast may still be undecided
module axis_packet_framer
  import axis_framer_pkg::*;
#(
  parameter int TID_WIDTH        = 2,
  parameter int TDEST_WIDTH      = 4,
  parameter int TDATA_WIDTH      = 512,
  parameter int MAX_PACKET_BEATS = 8,
  parameter int IDLE_TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TID_WIDTH-1:0]   s_axis_tid,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic                   s_axis_tflush,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [TID_WIDTH-1:0]   m_axis_tid,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest
);

  localparam int              IDX_W    = clog2_min1(MAX_PACKET_BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_PACKET_BEATS - 1);

  h_state_e               h_state_q, h_state_d;
  logic [TDATA_WIDTH-1:0] h_data_q,  h_data_d;
  logic [TID_WIDTH-1:0]   h_tid_q,   h_tid_d;
  logic [TDEST_WIDTH-1:0] h_tdest_q, h_tdest_d;
  logic [IDX_W-1:0]       h_idx_q,   h_idx_d;
  logic                   h_decided_q, h_decided_d;

  logic             o_ready;
  logic             accept;
  logic             key_change;
  logic             rel_h;
  logic             rel_last;
  logic             timeout_hit;
  logic [IDX_W-1:0] new_idx;

  // Ready does not wait on s_axis_tvalid: with a beat held and O able to
  // load, any arriving beat releases the held one through the new-beat rule,
  // so ready only needs H empty or O loadable.
  always_comb begin
    s_axis_tready = rst_n && ((h_state_q == H_EMPTY) || o_ready);
    accept        = s_axis_tvalid && s_axis_tready;
    key_change    = {s_axis_tid, s_axis_tdest} != {h_tid_q, h_tdest_q};
    rel_h         = (h_state_q == H_HOLD) && o_ready && (h_decided_q || accept);
    // A decided beat always closes its packet, even if the next key matches.
    rel_last      = h_decided_q || key_change;
    new_idx       = ((h_state_q == H_EMPTY) || rel_last) ? '0 : h_idx_q + 1'b1;
  end

  always_comb begin
    h_state_d   = h_state_q;
    h_data_d    = h_data_q;
    h_tid_d     = h_tid_q;
    h_tdest_d   = h_tdest_q;
    h_idx_d     = h_idx_q;
    h_decided_d = h_decided_q;
    if (accept) begin
      h_state_d   = H_HOLD;
      h_data_d    = s_axis_tdata;
      h_tid_d     = s_axis_tid;
      h_tdest_d   = s_axis_tdest;
      h_idx_d     = new_idx;
      h_decided_d = s_axis_tflush || (new_idx == LAST_IDX);
    end else if (rel_h) begin
      h_state_d   = H_EMPTY;
      h_decided_d = 1'b0;
    end else if (timeout_hit) begin
      h_decided_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state_q   <= H_EMPTY;
      h_data_q    <= '0;
      h_tid_q     <= '0;
      h_tdest_q   <= '0;
      h_idx_q     <= '0;
      h_decided_q <= 1'b0;
    end else begin
      h_state_q   <= h_state_d;
      h_data_q    <= h_data_d;
      h_tid_q     <= h_tid_d;
      h_tdest_q   <= h_tdest_d;
      h_idx_q     <= h_idx_d;
      h_decided_q <= h_decided_d;
    end
  end

`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
  localparam int               CNT_W     = clog2_min1(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IDLE_TIMEOUT);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // An accept on the would-be expiry cycle wins: the held beat leaves via
  // the new-beat rule and the count restarts.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
    if (accept) begin
      idle_cnt_d = '0;
    end else if ((h_state_q == H_HOLD) && !h_decided_q) begin
      if (idle_cnt_q + 1'b1 == CNT_LIMIT) begin
        timeout_hit = 1'b1;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_idle_timeout;
  assign timeout_hit         = 1'b0;
  assign unused_idle_timeout = ^IDLE_TIMEOUT;
`endif

  axis_framer_out_reg #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .TID_WIDTH   (TID_WIDTH),
    .TDEST_WIDTH (TDEST_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (rel_h),
    .in_ready      (o_ready),
    .in_tdata      (h_data_q),
    .in_tid        (h_tid_q),
    .in_tdest      (h_tdest_q),
    .in_tlast      (rel_last),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_axis_packet_framer.sv
// tb_axis_packet_framer
//   Scoreboard bench for axis_packet_framer. Expected output beats come from a
//   packet-level model (running length, key of the previous beat, flush) and
//   are queued as the stimulus is issued; a negedge monitor pops and compares
//   every output handshake and checks that stalled output beats stay stable.
module tb_axis_packet_framer;

  localparam int TDW  = 512;
  localparam int TIDW = 2;
  localparam int TDSW = 4;
  localparam int MAXB = 8;
  localparam int IDLE = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic [TDW-1:0]  s_tdata = '0;
  logic [TIDW-1:0] s_tid = '0;
  logic [TDSW-1:0] s_tdest = '0;
  logic            s_tflush = 1'b0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [TDW-1:0]  m_tdata;
  logic            m_tlast;
  logic [TIDW-1:0] m_tid;
  logic [TDSW-1:0] m_tdest;

  always #5 clk = ~clk;

  axis_packet_framer #(
    .TID_WIDTH        (TIDW),
    .TDEST_WIDTH      (TDSW),
    .TDATA_WIDTH      (TDW),
    .MAX_PACKET_BEATS (MAXB),
    .IDLE_TIMEOUT     (IDLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tid    (s_tid),
    .s_axis_tdest  (s_tdest),
    .s_axis_tflush (s_tflush),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tdest  (m_tdest)
  );

  typedef struct {
    logic [TDW-1:0]  data;
    logic [TIDW-1:0] tid;
    logic [TDSW-1:0] tdest;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    n_out = 0;
  int    ready_pct = 100;
  int    t_acc = 0;

  // packet-level reference model state
  bit    pend_valid = 1'b0;
  beat_t pend;
  int    run_len = 0;

  task automatic check(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet rules: a beat ends its packet if flushed, if it is the MAXB-th
  // beat of the packet, or if the next beat has a different {tid,tdest}.
  // The last rule is only known when the next beat shows up.
  task automatic model_issue(input logic [TDW-1:0] d, input logic [TIDW-1:0] id,
                             input logic [TDSW-1:0] ds, input logic fl);
    beat_t b;
    if (pend_valid) begin
      pend.last = ({pend.tid, pend.tdest} != {id, ds});
      exp_q.push_back(pend);
      pend_valid = 1'b0;
      if (pend.last) run_len = 0;
    end
    run_len++;
    b.data = d; b.tid = id; b.tdest = ds; b.last = 1'b1;
    if (fl || run_len == MAXB) begin
      exp_q.push_back(b);
      run_len = 0;
    end else begin
      pend = b;
      pend_valid = 1'b1;
    end
  endtask

  task automatic model_close_pending();
    if (pend_valid) begin
      pend.last = 1'b1;
      exp_q.push_back(pend);
      pend_valid = 1'b0;
    end
    run_len = 0;
  endtask

  function automatic logic [TDW-1:0] rand_data();
    logic [TDW-1:0] d;
    for (int i = 0; i < TDW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_beat(input logic [TDW-1:0] d, input logic [TIDW-1:0] id,
                           input logic [TDSW-1:0] ds, input logic fl);
    bit accepted;
    int waited;
    model_issue(d, id, ds, fl);
    s_tvalid = 1'b1; s_tdata = d; s_tid = id; s_tdest = ds; s_tflush = fl;
    accepted = 1'b0;
    waited = 0;
    while (!accepted && waited <= 1000) begin
      @(negedge clk);
      if (s_tready) accepted = 1'b1;
      @(posedge clk); #1;
      if (!accepted) waited++;
    end
    if (!accepted) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: beat not accepted in %0d cycles, required acceptance", waited);
    end
    t_acc = cyc;
    s_tvalid = 1'b0; s_tflush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    m_tready = ($urandom_range(99) < ready_pct);
  end

  // monitor
  initial begin
    bit    prev_stall;
    beat_t prev_b;
    beat_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", m_tvalid, 1'b1);
          check("stall_data",  m_tdata,  prev_b.data);
          check("stall_fields", {m_tid, m_tdest, m_tlast}, {prev_b.tid, prev_b.tdest, prev_b.last});
        end
        if (m_tvalid && m_tready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_beat: got tdest %0h tlast %0b with no beat expected", m_tdest, m_tlast);
          end else begin
            e = exp_q.pop_front();
            check("out_data",  m_tdata,  e.data);
            check("out_tid",   m_tid,    e.tid);
            check("out_tdest", m_tdest,  e.tdest);
            check("out_tlast", m_tlast,  e.last);
          end
        end
        prev_stall  = m_tvalid && !m_tready;
        prev_b.data = m_tdata; prev_b.tid = m_tid; prev_b.tdest = m_tdest; prev_b.last = m_tlast;
      end
    end
  end

  initial begin
    int base, t0, t_first, w;
    // reset values
    idle(3);
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tready", s_tready, 1'b0);
    check("rst_tdata",  m_tdata,  '0);
    check("rst_fields", {m_tid, m_tdest, m_tlast}, '0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("post_rst_tready", s_tready, 1'b1);
    @(posedge clk); #1;

    // max length, no flush: 8 + 8 emitted, last four held (one still in H)
    base = n_out;
    for (int i = 1; i <= 20; i++) send_beat(rand_data(), 2'd0, 4'd3, 1'b0);
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
    model_close_pending();
    idle(40);
    check("held_count", n_out - base, 20);
`else
    idle(40);
    check("held_count", n_out - base, 19);
`endif
    send_beat(rand_data(), 2'd1, 4'd9, 1'b1);

    // max length with flush on beat 20: tlast on 8, 16, 20
    for (int i = 1; i <= 20; i++) send_beat(rand_data(), 2'd0, 4'd3, i == 20);

    // destination change: 1,1,2,2 -> tlast 0,1,0,1
    send_beat(rand_data(), 2'd0, 4'd1, 1'b0);
    send_beat(rand_data(), 2'd0, 4'd1, 1'b0);
    send_beat(rand_data(), 2'd0, 4'd2, 1'b0);
    send_beat(rand_data(), 2'd0, 4'd2, 1'b1);
    idle(5);
    check("destchg_drained", exp_q.size(), 0);

    // throughput: 50 back-to-back beats take 50 consecutive cycles
    send_beat(rand_data(), 2'd2, 4'd4, 1'b0);
    t_first = t_acc;
    for (int i = 1; i < 50; i++) send_beat(rand_data(), 2'd2, 4'd4, 1'b0);
    check("throughput", t_acc - t_first, 49);
    send_beat(rand_data(), 2'd1, 4'd9, 1'b1);

    // backpressure with random keys, flushes and gaps
    ready_pct = 50;
    for (int i = 0; i < 100; i++) begin
      send_beat(rand_data(), TIDW'($urandom_range(1)), TDSW'($urandom_range(2)),
                $urandom_range(9) == 0);
      if ($urandom_range(9) < 3) idle($urandom_range(2));
    end
    send_beat(rand_data(), 2'd1, 4'd9, 1'b1);
    ready_pct = 100;
    idle(30);
    check("bp_drained", exp_q.size(), 0);

    // idle timeout behaviour
`ifdef AXIS_PACKET_FRAMER_TIMEOUT_EN
    send_beat(rand_data(), 2'd0, 4'd5, 1'b0);
    t0 = t_acc;
    model_close_pending();
    w = 0;
    while (!m_tvalid && w < 100) begin @(negedge clk); w++; end
    check("timeout_latency", cyc - t0, IDLE + 1);
    check("timeout_tlast", m_tlast, 1'b1);
    idle(3);
    // collision: second beat accepted on the expiry cycle
    send_beat(rand_data(), 2'd0, 4'd5, 1'b0);
    t0 = t_acc;
    repeat (IDLE - 1) @(posedge clk);
    #1;
    send_beat(rand_data(), 2'd0, 4'd5, 1'b0);
    check("collision_cycle", t_acc - t0, IDLE);
    model_close_pending();
    idle(IDLE + 5);
`else
    send_beat(rand_data(), 2'd0, 4'd5, 1'b0);
    base = n_out;
    idle(1000);
    check("no_timeout", n_out - base, 0);
    send_beat(rand_data(), 2'd1, 4'd9, 1'b1);
`endif

    // asynchronous reset mid-packet
    for (int i = 0; i < 3; i++) send_beat(rand_data(), 2'd1, 4'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid, 1'b0);
    check("midrst_tready", s_tready, 1'b0);
    exp_q.delete();
    pend_valid = 1'b0;
    run_len = 0;
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send_beat(rand_data(), 2'd1, 4'd7, 1'b0);
    send_beat(rand_data(), 2'd1, 4'd9, 1'b1);

    idle(20);
    check("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
